// File: rtl/mem_access_unit.sv
// Load/store initiator for a single-cycle word-wide data memory; sub-word accesses use RMW.
// Optional feature macro: MEM_ACCESS_SUBWORD_EN (byte/halfword loads and stores).
module mem_access_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StErr} state_e;

    state_e      r_state, w_next;
    logic [29:0] r_word_addr;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        w_illegal;
    logic        w_misalign;
    logic [31:0] w_load_data;
`ifdef MEM_ACCESS_SUBWORD_EN
    logic [1:0]  r_lane;
    logic [2:0]  r_funct3;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_merged;
`endif

    // Request legality and alignment, evaluated on the incoming request
    always_comb begin
        w_illegal  = 1'b1;
        w_misalign = 1'b0;
`ifdef MEM_ACCESS_SUBWORD_EN
        case (i_req_funct3)
            3'b000: w_illegal = 1'b0;
            3'b001: begin
                w_illegal  = 1'b0;
                w_misalign = i_req_addr[0];
            end
            3'b010: begin
                w_illegal  = 1'b0;
                w_misalign = |i_req_addr[1:0];
            end
            3'b100: w_illegal = i_req_we;
            3'b101: begin
                w_illegal  = i_req_we;
                w_misalign = i_req_addr[0];
            end
            default: ;
        endcase
`else
        if (i_req_funct3 == 3'b010) begin
            w_illegal  = 1'b0;
            w_misalign = |i_req_addr[1:0];
        end
`endif
    end

`ifdef MEM_ACCESS_SUBWORD_EN
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = i_mem_rdata;
        endcase
        // funct3[0] distinguishes SH from SB; only those two reach RMW_RD
        w_merged = i_mem_rdata;
        if (r_funct3[0]) begin
            if (r_lane[1]) w_merged[31:16] = r_wdata[15:0];
            else           w_merged[15:0]  = r_wdata[15:0];
        end else begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end
    end
`else
    assign w_load_data = i_mem_rdata;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    if (w_illegal || w_misalign) w_next = StErr;
                    else if (!i_req_we)          w_next = StLoad;
`ifdef MEM_ACCESS_SUBWORD_EN
                    else if (i_req_funct3 != 3'b010) w_next = StRmwRd;
`endif
                    else                         w_next = StWrite;
                end
            end
`ifdef MEM_ACCESS_SUBWORD_EN
            StRmwRd: w_next = StWrite;
`endif
            StLoad, StWrite, StErr: w_next = StIdle;
            default: w_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word_addr  <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
`ifdef MEM_ACCESS_SUBWORD_EN
            r_lane       <= '0;
            r_funct3     <= '0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_word_addr <= i_req_addr[31:2];
                        r_wdata     <= i_req_wdata;
`ifdef MEM_ACCESS_SUBWORD_EN
                        r_lane      <= i_req_addr[1:0];
                        r_funct3    <= i_req_funct3;
`endif
                    end
                end
                StLoad: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                end
`ifdef MEM_ACCESS_SUBWORD_EN
                StRmwRd: r_wdata <= w_merged;
`endif
                StWrite: r_resp_valid <= 1'b1;
                StErr: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready  = (r_state == StIdle);
    assign o_mem_read   = (r_state == StLoad) || (r_state == StRmwRd);
    assign o_mem_write  = (r_state == StWrite);
    assign o_mem_wdata  = (r_state == StWrite) ? r_wdata : 32'h0;
    assign o_mem_addr   = (r_state == StIdle) ? 32'h0 : {2'b00, r_word_addr};
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural single-cycle word memory.
// Expectations follow MEM_ACCESS_SUBWORD_EN when it is defined for the build.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63] = '{default: 32'h0};

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[5:0]];

    mem_access_unit dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_resp_valid (resp_valid),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err),
        .o_mem_addr   (mem_addr),
        .o_mem_read   (mem_read),
        .o_mem_write  (mem_write),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   rd_cyc = 0;
    int   wr_cyc = 0;
    int   resp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: protocol checks and scoreboard pops on every response
    always @(negedge clk) begin
        exp_t e;
        check("mem_rw_exclusive", {31'h0, mem_read & mem_write}, 32'h0);
        if (mem_read)  rd_cyc++;
        if (mem_write) wr_cyc++;
        if (resp_valid) begin
            resp_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_resp", 32'h1, 32'h0);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_err"}, {31'h0, resp_err}, {31'h0, e.err});
                check({e.name, "_rdata"}, resp_rdata, e.rdata);
            end
        end
    end

    task automatic issue(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rd, input int exp_lat,
                         input int exp_nrd, input int exp_nwr);
        exp_t e;
        int   rd0, wr0, lat;
        @(negedge clk);
        check({name, "_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        e.err   = exp_err;
        e.rdata = exp_rd;
        e.name  = name;
        sb_q.push_back(e);
        rd0 = rd_cyc;
        wr0 = wr_cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (!exp_err) check({name, "_mem_addr"}, mem_addr, {2'b00, addr[31:2]});
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!resp_valid && lat < 8);
        check({name, "_latency"}, lat, exp_lat);
        @(negedge clk);
        check({name, "_reads"}, rd_cyc - rd0, exp_nrd);
        check({name, "_writes"}, wr_cyc - wr0, exp_nwr);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int resp0, wr0;
        #12;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_mem_addr", mem_addr, 32'h0);
        check("idle_mem_wdata", mem_wdata, 32'h0);
        check("idle_resp", {resp_rdata[30:0], resp_err}, 32'h0);

        // Word store/load round trip
        issue("sw08", 1, 3'b010, 32'h08, 32'hDEADBEEF, 0, 32'h0, 1, 0, 1);
        check("mem2", mem[2], 32'hDEADBEEF);
        issue("lw08", 0, 3'b010, 32'h08, 32'h0, 0, 32'hDEADBEEF, 1, 1, 0);
        issue("lw_wrap", 0, 3'b010, 32'hFFFF_FF08, 32'h0, 0, 32'hDEADBEEF, 1, 1, 0);

        // Byte and halfword stores by read-modify-write
        issue("sw0c", 1, 3'b010, 32'h0C, 32'h11223344, 0, 32'h0, 1, 0, 1);
        issue("sb0d", 1, 3'b000, 32'h0D, 32'h00000055, !SUB, 32'h0,
              SUB ? 2 : 1, SUB ? 1 : 0, SUB ? 1 : 0);
        check("mem3_sb", mem[3], SUB ? 32'h11225544 : 32'h11223344);
        issue("sh0e", 1, 3'b001, 32'h0E, 32'h0000ABCD, !SUB, 32'h0,
              SUB ? 2 : 1, SUB ? 1 : 0, SUB ? 1 : 0);
        check("mem3_sh", mem[3], SUB ? 32'hABCD5544 : 32'h11223344);

        // Sub-word loads with sign/zero extension
        issue("sw10", 1, 3'b010, 32'h10, 32'h80FF7F00, 0, 32'h0, 1, 0, 1);
        issue("lb13", 0, 3'b000, 32'h13, 32'h0, !SUB, SUB ? 32'hFFFFFF80 : 32'h0,
              1, SUB ? 1 : 0, 0);
        issue("lbu13", 0, 3'b100, 32'h13, 32'h0, !SUB, SUB ? 32'h00000080 : 32'h0,
              1, SUB ? 1 : 0, 0);
        issue("lh10", 0, 3'b001, 32'h10, 32'h0, !SUB, SUB ? 32'h00007F00 : 32'h0,
              1, SUB ? 1 : 0, 0);
        issue("lhu12", 0, 3'b101, 32'h12, 32'h0, !SUB, SUB ? 32'h000080FF : 32'h0,
              1, SUB ? 1 : 0, 0);
        issue("lb00", 0, 3'b000, 32'h00, 32'h0, !SUB, 32'h0, 1, SUB ? 1 : 0, 0);

        // Errors never touch memory
        issue("lw06_mis", 0, 3'b010, 32'h06, 32'h0, 1, 32'h0, 1, 0, 0);
        issue("lh03_mis", 0, 3'b001, 32'h03, 32'h0, 1, 32'h0, 1, 0, 0);
        issue("f3_011", 0, 3'b011, 32'h00, 32'h0, 1, 32'h0, 1, 0, 0);
        issue("sbu_store", 1, 3'b100, 32'h10, 32'h0, 1, 32'h0, 1, 0, 0);
        issue("sw0e_mis", 1, 3'b010, 32'h0E, 32'h12345678, 1, 32'h0, 1, 0, 0);
        check("mem3_after_err", mem[3], SUB ? 32'hABCD5544 : 32'h11223344);

        // Reset while an SH sits in its read phase
        issue("sw14", 1, 3'b010, 32'h14, 32'hCAFEF00D, 0, 32'h0, 1, 0, 1);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h14;
        req_wdata  = 32'h00001234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("sh14_in_rmw_read", {31'h0, mem_read}, {31'h0, SUB});
        resp0 = resp_cnt;
        wr0   = wr_cyc;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'h0, req_ready}, 32'h1);
        check("midrst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_resp", resp_cnt - resp0, 0);
        check("midrst_no_write", wr_cyc - wr0, 0);
        check("mem5_unchanged", mem[5], 32'hCAFEF00D);
        issue("lw14", 0, 3'b010, 32'h14, 32'h0, 0, 32'hCAFEF00D, 1, 1, 0);

        repeat (2) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Pipeline-side initiator for the single-cycle word-wide data memory: accepts one load/store request at a time from the MEM stage and drives that memory's address/read/write port. Converts byte addresses to word indices, performs byte and halfword stores as read-modify-write, and extracts/sign-extends loaded bytes and halfwords. Returns one response per request, flagging misaligned or illegal accesses without touching memory.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; 1 only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned or illegal access, valid with resp_valid
- mem_addr  out  32  word index {2'b00, addr[31:2]}
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable, committed on rising edge
- mem_wdata  out  32  word written
- mem_rdata  in  32  combinational read data for mem_addr

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, ERR.
- IDLE: req_ready=1; on req_valid, latch we/funct3/addr/wdata. Illegal funct3 (011, 110, 111; 100/101 with we=1) or misalignment (H with addr[0]=1, W with addr[1:0]≠0) -> ERR. Otherwise load -> LOAD, SW -> WRITE (mem_wdata=wdata), SB/SH -> RMW_RD.
- LOAD: mem_read=1; at edge capture extracted data into resp_rdata, pulse resp_valid, -> IDLE. Byte lane addr[1:0], half lane addr[1]; B/H sign-extend, BU/HU zero-extend, W pass-through.
- RMW_RD: mem_read=1; at edge latch merged word (SB replaces lane addr[1:0] with wdata[7:0]; SH replaces lane addr[1] with wdata[15:0]) -> WRITE.
- WRITE: mem_write=1, mem_wdata=merged/full word; at edge pulse resp_valid (resp_rdata=0) -> IDLE.
- ERR: no mem_read/mem_write; at edge pulse resp_valid with resp_err=1, resp_rdata=0 -> IDLE.
- mem_read and mem_write never high together; both 0 in IDLE and ERR; mem_addr held from latched address outside IDLE, 0 in IDLE.

## Timing
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_wdata=0, latched request cleared. Outputs drop asynchronously.
- Latency from accept edge to resp_valid: load 1 cycle, SW 1, SB/SH 2, error 1.
- resp_valid is registered, high exactly one cycle; req_ready is high in the same cycle, so back-to-back requests issue every 2 cycles (loads/SW).
- req_valid ignored while req_ready=0; requester must hold it until accepted.
- Reset during RMW_RD or before WRITE edge: memory unchanged, no response issued.
- Address wrap: addr[31:2] passed unchanged; memory decodes low bits.

## Configuration
- MEM_ACCESS_SUBWORD_EN defined: B/H/BU/HU loads and SB/SH via RMW as above.
- Undefined: only funct3=010 legal; all other codes -> ERR; RMW_RD state and lane logic absent.

## Test plan
- SW addr 0x08 data 0xDEADBEEF, then LW 0x08 -> mem_addr=2, mem_write one cycle, LW resp_rdata=0xDEADBEEF, resp_err=0.
- Word 0x11223344 at 0x0C; SB addr 0x0D data 0x55 -> mem_read then mem_write cycle, word becomes 0x11225544, response 2 cycles after accept.
- Word 0x80FF7F00 at 0x10: LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x10 -> 0x00007F00; LHU 0x12 -> 0x000080FF.
- LW addr 0x06, LH addr 0x03, funct3=011 -> each resp_err=1, resp_rdata=0, mem_read/mem_write never asserted.
- rst_n low in RMW_RD of SH 0x14 -> state IDLE, no mem_write, no resp_valid, memory word unchanged.
- Macro undefined: LB 0x00 -> resp_err=1 with no memory access.
